// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared types for the multi-cycle ARM control unit: FSM states,
// ALU control codes, datapath select codes and ARM condition codes.
package multi_cycle_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_UNKNOWN  = 4'd10
   } state_e;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_ORR = 2'b11
   } alu_ctrl_e;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
      COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
      COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
      COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
   } cond_e;

   // Data-processing cmd field values recognised by the ALU decoder
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic       SRCA_REG      = 1'b0;
   localparam logic       SRCA_PC       = 1'b1;
   localparam logic       ADR_PC        = 1'b0;
   localparam logic       ADR_RESULT    = 1'b1;
   localparam logic [1:0] SRCB_REG      = 2'b00;
   localparam logic [1:0] SRCB_IMM      = 2'b01;
   localparam logic [1:0] SRCB_FOUR     = 2'b10;
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Instruction fields and ALU flags into the controller, mux selects and
// write enables out to the datapath. master = controller, slave = datapath.
interface multi_cycle_ctrl_if;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] cond;
   logic [3:0] alu_flags;
   logic       ir_write;
   logic       pc_write;
   logic       reg_write;
   logic       mem_write;
   logic       adr_src;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] result_src;
   logic [1:0] alu_control;
   logic       illegal_op;

   modport master (
      input  op, funct, cond, alu_flags,
      output ir_write, pc_write, reg_write, mem_write, adr_src, alu_src_a,
             alu_src_b, result_src, alu_control, illegal_op
   );

   modport slave (
      output op, funct, cond, alu_flags,
      input  ir_write, pc_write, reg_write, mem_write, adr_src, alu_src_a,
             alu_src_b, result_src, alu_control, illegal_op
   );
endinterface

// File: rtl/multi_cycle_ctrl_cond_logic.sv
// NZCV flag register, ARM condition evaluation and condition-gated
// write enables. cond_ex_q is captured once per instruction in DECODE.
module cond_logic
   import multi_cycle_pkg::*;
#(
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond_i,
   input  logic [3:0] alu_flags_i,
   input  logic       latch_cond_i,
   input  logic [1:0] flag_w_i,
   input  logic       next_pc_i,
   input  logic       branch_i,
   input  logic       regw_i,
   input  logic       memw_i,
   output logic       pc_write_o,
   output logic       reg_write_o,
   output logic       mem_write_o
);

   logic [3:0] flags_q;
   logic       cond_ex_q;
   logic       cond_ok;

   function automatic logic condcheck(input logic [3:0] c, input logic [3:0] nzcv);
      logic n, z, cy, v;
      {n, z, cy, v} = nzcv;
      case (cond_e'(c))
         COND_EQ: return z;
         COND_NE: return !z;
         COND_CS: return cy;
         COND_CC: return !cy;
         COND_MI: return n;
         COND_PL: return !n;
         COND_VS: return v;
         COND_VC: return !v;
         COND_HI: return cy & !z;
         COND_LS: return !cy | z;
         COND_GE: return n == v;
         COND_LT: return n != v;
         COND_GT: return !z & (n == v);
         COND_LE: return z | (n != v);
         default: return 1'b1;
      endcase
   endfunction

   // Evaluate the instruction's condition against the current flags
   always_comb cond_ok = condcheck(cond_i, flags_q);

   // Capture the condition result in DECODE; held until the next DECODE
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!reset)            cond_ex_q <= 1'b0;
      else if (latch_cond_i) cond_ex_q <= cond_ok;
   end

   // Update N,Z and C,V independently when the executing instruction passes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags_q <= RESET_FLAGS;
      end else begin
         if (flag_w_i[1] && cond_ex_q) flags_q[3:2] <= alu_flags_i[3:2];
         if (flag_w_i[0] && cond_ex_q) flags_q[1:0] <= alu_flags_i[1:0];
      end
   end

   // Enables drop as soon as reset is asserted, independent of the clock
   assign pc_write_o  = reset & (next_pc_i | (branch_i & cond_ex_q));
   assign reg_write_o = reset & regw_i & cond_ex_q;
   assign mem_write_o = reset & memw_i & cond_ex_q;

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle ARM control unit: Moore FSM sequencing the datapath, ALU
// decode, and condition-gated write enables from cond_logic.
module multi_cycle_ctrl
   import multi_cycle_pkg::*;
#(
   parameter bit         HALT_ON_UNKNOWN = 1'b0,
   parameter logic [3:0] RESET_FLAGS     = 4'b0000
) (
   input  logic               clk,
   input  logic               reset,
   multi_cycle_ctrl_if.master bus
);

   state_e    state_q, state_d;
   alu_ctrl_e alu_ctrl;
   logic [1:0] flag_w;
   logic       alu_op, next_pc, branch, regw, memw, ir_w, illegal;
   logic       adr_src, alu_src_a;
   logic [1:0] alu_src_b, result_src;

   // Next-state selection from the current state and instruction fields
   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               2'b01:   state_d = S_MEMADR;
               2'b00:   state_d = bus.funct[5] ? S_EXECUTEI : S_EXECUTER;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_UNKNOWN;
            endcase
         end
         S_MEMADR:   state_d = bus.funct[0] ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_UNKNOWN:  state_d = HALT_ON_UNKNOWN ? S_UNKNOWN : S_FETCH;
         default:    state_d = S_FETCH;
      endcase
   end

   // State register; reset parks the FSM in FETCH
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Moore output decode; anything not named for a state stays 0
   always_comb begin
      adr_src    = ADR_PC;
      alu_src_a  = SRCA_REG;
      alu_src_b  = SRCB_REG;
      result_src = RES_ALUOUT;
      ir_w       = 1'b0;
      next_pc    = 1'b0;
      regw       = 1'b0;
      memw       = 1'b0;
      branch     = 1'b0;
      alu_op     = 1'b0;
      illegal    = 1'b0;
      case (state_q)
         S_FETCH: begin
            alu_src_a = SRCA_PC; alu_src_b = SRCB_FOUR; result_src = RES_ALURESULT;
            ir_w = 1'b1; next_pc = 1'b1;
         end
         S_DECODE: begin
            alu_src_a = SRCA_PC; alu_src_b = SRCB_FOUR; result_src = RES_ALURESULT;
         end
         S_MEMADR:   alu_src_b = SRCB_IMM;
         S_MEMREAD:  adr_src = ADR_RESULT;
         S_MEMWB:    begin result_src = RES_DATA; regw = 1'b1; end
         S_MEMWRITE: begin adr_src = ADR_RESULT; memw = 1'b1; end
         S_EXECUTER: alu_op = 1'b1;
         S_EXECUTEI: begin alu_src_b = SRCB_IMM; alu_op = 1'b1; end
         S_ALUWB:    regw = 1'b1;
         S_BRANCH: begin
            alu_src_b = SRCB_IMM; result_src = RES_ALURESULT; branch = 1'b1;
         end
         S_UNKNOWN:  illegal = 1'b1;
         default:    ;
      endcase
   end

   // ALU operation and flag-write mask; unrecognised cmds add without touching flags
   always_comb begin
      alu_ctrl = ALU_ADD;
      flag_w   = 2'b00;
      if (alu_op) begin
         case (bus.funct[4:1])
            CMD_ADD: begin alu_ctrl = ALU_ADD; flag_w = {2{bus.funct[0]}};     end
            CMD_SUB: begin alu_ctrl = ALU_SUB; flag_w = {2{bus.funct[0]}};     end
            CMD_AND: begin alu_ctrl = ALU_AND; flag_w = {bus.funct[0], 1'b0}; end
            CMD_ORR: begin alu_ctrl = ALU_ORR; flag_w = {bus.funct[0], 1'b0}; end
            default: begin alu_ctrl = ALU_ADD; flag_w = 2'b00;                end
         endcase
      end
   end

   cond_logic #(.RESET_FLAGS(RESET_FLAGS)) u_cond (
      .clk          (clk),
      .reset        (reset),
      .cond_i       (bus.cond),
      .alu_flags_i  (bus.alu_flags),
      .latch_cond_i (state_q == S_DECODE),
      .flag_w_i     (flag_w),
      .next_pc_i    (next_pc),
      .branch_i     (branch),
      .regw_i       (regw),
      .memw_i       (memw),
      .pc_write_o   (bus.pc_write),
      .reg_write_o  (bus.reg_write),
      .mem_write_o  (bus.mem_write)
   );

   assign bus.ir_write    = reset & ir_w;
   assign bus.adr_src     = adr_src;
   assign bus.alu_src_a   = alu_src_a;
   assign bus.alu_src_b   = alu_src_b;
   assign bus.result_src  = result_src;
   assign bus.alu_control = alu_ctrl;
   assign bus.illegal_op  = illegal;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: a non-halting instance runs an
// instruction sequence, a halting instance covers sticky UNKNOWN.
module tb_multi_cycle_ctrl;

   logic clk = 1'b0;
   logic rst0_n, rst1_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   multi_cycle_ctrl_if bus0 ();
   multi_cycle_ctrl_if bus1 ();

   multi_cycle_ctrl #(.HALT_ON_UNKNOWN(1'b0), .RESET_FLAGS(4'b0000)) dut0 (
      .clk (clk), .reset (rst0_n), .bus (bus0.master)
   );
   multi_cycle_ctrl #(.HALT_ON_UNKNOWN(1'b1), .RESET_FLAGS(4'b0100)) dut1 (
      .clk (clk), .reset (rst1_n), .bus (bus1.master)
   );

   // Output signature: {ir,pc,reg,mem, adr, a, b[1:0], res[1:0], alu[1:0], illegal}
   logic [13:0] sig0, sig1;
   assign sig0 = {bus0.ir_write, bus0.pc_write, bus0.reg_write, bus0.mem_write,
                  bus0.adr_src, bus0.alu_src_a, bus0.alu_src_b, bus0.result_src,
                  bus0.alu_control, bus0.illegal_op};
   assign sig1 = {bus1.ir_write, bus1.pc_write, bus1.reg_write, bus1.mem_write,
                  bus1.adr_src, bus1.alu_src_a, bus1.alu_src_b, bus1.result_src,
                  bus1.alu_control, bus1.illegal_op};

   localparam logic [13:0] V_FETCH   = 14'b1100_0_1_10_10_00_0;
   localparam logic [13:0] V_RSTF    = 14'b0000_0_1_10_10_00_0;
   localparam logic [13:0] V_DECODE  = 14'b0000_0_1_10_10_00_0;
   localparam logic [13:0] V_EXEI    = 14'b0000_0_0_01_00_00_0;
   localparam logic [13:0] V_EXER_S  = 14'b0000_0_0_00_00_01_0;
   localparam logic [13:0] V_EXER_A  = 14'b0000_0_0_00_00_10_0;
   localparam logic [13:0] V_ALUWB   = 14'b0010_0_0_00_00_00_0;
   localparam logic [13:0] V_ALUWB_N = 14'b0000_0_0_00_00_00_0;
   localparam logic [13:0] V_BR_T    = 14'b0100_0_0_01_10_00_0;
   localparam logic [13:0] V_BR_N    = 14'b0000_0_0_01_10_00_0;
   localparam logic [13:0] V_MEMADR  = 14'b0000_0_0_01_00_00_0;
   localparam logic [13:0] V_MEMRD   = 14'b0000_1_0_00_00_00_0;
   localparam logic [13:0] V_MEMWB   = 14'b0010_0_0_00_01_00_0;
   localparam logic [13:0] V_MEMWR   = 14'b0001_1_0_00_00_00_0;
   localparam logic [13:0] V_UNK     = 14'b0000_0_0_00_00_00_1;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc0(input string tag, input logic [13:0] exp);
      @(negedge clk);
      chk(tag, {2'b00, sig0}, {2'b00, exp});
   endtask

   task automatic cyc1(input string tag, input logic [13:0] exp);
      @(negedge clk);
      chk(tag, {2'b00, sig1}, {2'b00, exp});
   endtask

   task automatic instr0(input logic [1:0] op, input logic [5:0] funct,
                         input logic [3:0] cond, input logic [3:0] flags);
      bus0.op = op; bus0.funct = funct; bus0.cond = cond; bus0.alu_flags = flags;
   endtask

   initial begin
      rst0_n = 1'b0;
      rst1_n = 1'b0;
      bus1.op = 2'b11; bus1.funct = 6'b0; bus1.cond = 4'b1110; bus1.alu_flags = 4'b0;

      // ADDS imm, always; ALU reports Z
      instr0(2'b00, 6'b101001, 4'b1110, 4'b0100);
      cyc0("rst_c1", V_RSTF);
      cyc0("rst_c2", V_RSTF);
      cyc0("rst_c3", V_RSTF);
      @(posedge clk); #2 rst0_n = 1'b1;

      cyc0("adds_fetch", V_FETCH);
      cyc0("adds_decode", V_DECODE);
      cyc0("adds_exei", V_EXEI);
      cyc0("adds_aluwb", V_ALUWB);
      chk("adds_flags", {12'd0, dut0.u_cond.flags_q}, 16'h0004);

      // BEQ with Z=1: taken, three cycles
      instr0(2'b10, 6'b000000, 4'b0000, 4'b0000);
      cyc0("beqt_fetch", V_FETCH);
      cyc0("beqt_decode", V_DECODE);
      cyc0("beqt_branch", V_BR_T);

      // SUBS reg, always; ALU reports C
      instr0(2'b00, 6'b000101, 4'b1110, 4'b0010);
      cyc0("subs_fetch", V_FETCH);
      cyc0("subs_decode", V_DECODE);
      cyc0("subs_exer", V_EXER_S);
      cyc0("subs_aluwb", V_ALUWB);
      chk("subs_flags", {12'd0, dut0.u_cond.flags_q}, 16'h0002);

      // BEQ with Z=0: not taken
      instr0(2'b10, 6'b000000, 4'b0000, 4'b0000);
      cyc0("beqn_fetch", V_FETCH);
      cyc0("beqn_decode", V_DECODE);
      cyc0("beqn_branch", V_BR_N);

      // LDR: five cycles
      instr0(2'b01, 6'b011001, 4'b1110, 4'b0000);
      cyc0("ldr_fetch", V_FETCH);
      cyc0("ldr_decode", V_DECODE);
      cyc0("ldr_memadr", V_MEMADR);
      cyc0("ldr_memrd", V_MEMRD);
      cyc0("ldr_memwb", V_MEMWB);

      // STR: four cycles, mem_write only in the last
      instr0(2'b01, 6'b011000, 4'b1110, 4'b0000);
      cyc0("str_fetch", V_FETCH);
      cyc0("str_decode", V_DECODE);
      cyc0("str_memadr", V_MEMADR);
      cyc0("str_memwr", V_MEMWR);

      // ADDS imm again to set Z=1
      instr0(2'b00, 6'b101001, 4'b1110, 4'b0100);
      cyc0("adds2_fetch", V_FETCH);
      cyc0("adds2_decode", V_DECODE);
      cyc0("adds2_exei", V_EXEI);
      cyc0("adds2_aluwb", V_ALUWB);

      // SUBSNE with Z=1: fails, no write and no flag update
      instr0(2'b00, 6'b000101, 4'b0001, 4'b1011);
      cyc0("subne_fetch", V_FETCH);
      cyc0("subne_decode", V_DECODE);
      cyc0("subne_exer", V_EXER_S);
      cyc0("subne_aluwb", V_ALUWB_N);
      chk("subne_flags", {12'd0, dut0.u_cond.flags_q}, 16'h0004);

      // ANDS: N,Z updated from 10, C,V kept at 00
      instr0(2'b00, 6'b000001, 4'b1110, 4'b1011);
      cyc0("ands_fetch", V_FETCH);
      cyc0("ands_decode", V_DECODE);
      cyc0("ands_exer", V_EXER_A);
      cyc0("ands_aluwb", V_ALUWB);
      chk("ands_flags", {12'd0, dut0.u_cond.flags_q}, 16'h0008);

      // op=11: one UNKNOWN cycle then FETCH
      instr0(2'b11, 6'b000000, 4'b1110, 4'b0000);
      cyc0("unk_fetch", V_FETCH);
      cyc0("unk_decode", V_DECODE);
      cyc0("unk_state", V_UNK);

      // STR interrupted by reset while in MEMWRITE
      instr0(2'b01, 6'b011000, 4'b1110, 4'b0000);
      cyc0("unk_next_fetch", V_FETCH);
      cyc0("strr_decode", V_DECODE);
      cyc0("strr_memadr", V_MEMADR);
      cyc0("strr_memwr", V_MEMWR);
      #1 rst0_n = 1'b0;
      #1 chk("strr_rst_sig", {2'b00, sig0}, {2'b00, V_RSTF});
      chk("strr_rst_flags", {12'd0, dut0.u_cond.flags_q}, 16'h0000);
      @(posedge clk); #2 rst0_n = 1'b1;
      cyc0("strr_refetch", V_FETCH);
      cyc0("strr_redecode", V_DECODE);

      // Halting instance: UNKNOWN is sticky until reset
      @(posedge clk); #2 rst1_n = 1'b1;
      cyc1("halt_fetch", V_FETCH);
      cyc1("halt_decode", V_DECODE);
      cyc1("halt_unk1", V_UNK);
      cyc1("halt_unk2", V_UNK);
      cyc1("halt_unk3", V_UNK);
      cyc1("halt_unk4", V_UNK);
      chk("halt_flags", {12'd0, dut1.u_cond.flags_q}, 16'h0004);
      #1 rst1_n = 1'b0;
      #1 chk("halt_rst_sig", {2'b00, sig1}, {2'b00, V_RSTF});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
